// File: rtl/param_program_sequencer.sv
// param_program_sequencer: program counter with jump/call/return and a bounded return-address stack
module param_program_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic              call,
    input  logic              ret,
    input  logic              hold,
    input  logic              clr_err,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf_err,
    output logic              unf_err
);
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] inc, top;
    logic do_ret, do_call, ovf_set, unf_set;

    assign inc         = pc + 1'b1;
    assign stack_full  = sp == SP_W'(STACK_DEPTH);
    assign stack_empty = sp == '0;
    assign do_ret      = !hold && ret && !stack_empty;
    assign unf_set     = !hold && ret && stack_empty;
    assign do_call     = !hold && !ret && call && !stack_full;
    assign ovf_set     = !hold && !ret && call && stack_full;

    // top of stack is the entry just below sp; a mux avoids index-width mismatch
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == SP_W'(i + 1)) top = stack[i];
    end

    assign pm_addr = reset ? '0 :
                     hold  ? pc :
                     ret   ? (stack_empty ? inc : top) :
                     call  ? (stack_full ? inc : jmp_addr) :
                     jmp   ? jmp_addr :
                     (jmp_nz && !dont_jmp) ? jmp_addr : inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            sp      <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            pc <= pm_addr;
            sp <= do_call ? sp + 1'b1 : do_ret ? sp - 1'b1 : sp;
            if (!hold) begin
                ovf_err <= ovf_set | (ovf_err & ~clr_err);
                unf_err <= unf_set | (unf_err & ~clr_err);
            end
            for (int i = 0; i < STACK_DEPTH; i++)
                if (do_call && sp == SP_W'(i)) stack[i] <= inc;
        end
    end
endmodule

// File: tb/tb_param_program_sequencer.sv
// tb_param_program_sequencer: table-driven directed test of the program sequencer
module tb_param_program_sequencer;
    localparam logic [6:0] J = 7'd64, NZ = 7'd32, DJ = 7'd16, C = 7'd8, R = 7'd4, H = 7'd2, CL = 7'd1;

    typedef struct {
        logic [6:0] req;
        logic [7:0] addr;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic clk = 0, reset = 1;
    logic jmp = 0, jmp_nz = 0, dont_jmp = 0, call = 0, ret = 0, hold = 0, clr_err = 0;
    logic [7:0] jmp_addr = 0, pm_addr, pc;
    logic [2:0] sp;
    logic stack_full, stack_empty, ovf_err, unf_err;
    int n_cmp = 0, n_bad = 0, n = 0;
    vec_t tbl [32];

    param_program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .SP_W(3)) dut (
        .clk(clk), .reset(reset), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
        .call(call), .ret(ret), .hold(hold), .clr_err(clr_err), .jmp_addr(jmp_addr),
        .pm_addr(pm_addr), .pc(pc), .sp(sp), .stack_full(stack_full),
        .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [6:0] r, input logic [7:0] a);
        {jmp, jmp_nz, dont_jmp, call, ret, hold, clr_err} = r;
        jmp_addr = a;
    endtask

    task automatic add(input logic [6:0] r, input logic [7:0] a, input logic [7:0] p,
                       input logic [2:0] s, input logic f, input logic e, input logic o, input logic u);
        tbl[n] = '{r, a, p, s, f, e, o, u};
        n++;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] p, input logic [2:0] s,
                             input logic f, input logic e, input logic o, input logic u);
        chk({tag, " pc"}, 32'(pc), 32'(p));
        chk({tag, " sp"}, 32'(sp), 32'(s));
        chk({tag, " full"}, 32'(stack_full), 32'(f));
        chk({tag, " empty"}, 32'(stack_empty), 32'(e));
        chk({tag, " ovf"}, 32'(ovf_err), 32'(o));
        chk({tag, " unf"}, 32'(unf_err), 32'(u));
    endtask

    initial begin
        //   req      addr   pc     sp full empty ovf unf
        add(0,       8'h00, 8'h01, 0, 0, 1, 0, 0);
        add(0,       8'h00, 8'h02, 0, 0, 1, 0, 0);
        add(0,       8'h00, 8'h03, 0, 0, 1, 0, 0);
        add(J,       8'h10, 8'h10, 0, 0, 1, 0, 0);
        add(C,       8'h40, 8'h40, 1, 0, 0, 0, 0);
        add(0,       8'h00, 8'h41, 1, 0, 0, 0, 0);
        add(R,       8'h00, 8'h11, 0, 0, 1, 0, 0);
        add(J,       8'h05, 8'h05, 0, 0, 1, 0, 0);
        add(R,       8'h00, 8'h06, 0, 0, 1, 0, 1);
        add(CL,      8'h00, 8'h07, 0, 0, 1, 0, 0);
        add(NZ | DJ, 8'h30, 8'h08, 0, 0, 1, 0, 0);
        add(NZ,      8'h30, 8'h30, 0, 0, 1, 0, 0);
        add(H | J,   8'h50, 8'h30, 0, 0, 1, 0, 0);
        add(C | R,   8'h70, 8'h31, 0, 0, 1, 0, 1);
        add(CL | R,  8'h00, 8'h32, 0, 0, 1, 0, 1);
        add(CL,      8'h00, 8'h33, 0, 0, 1, 0, 0);
        add(J,       8'hFF, 8'hFF, 0, 0, 1, 0, 0);
        add(0,       8'h00, 8'h00, 0, 0, 1, 0, 0);
        add(C,       8'h20, 8'h20, 1, 0, 0, 0, 0);
        add(C,       8'h20, 8'h20, 2, 0, 0, 0, 0);
        add(C,       8'h20, 8'h20, 3, 0, 0, 0, 0);
        add(C,       8'h20, 8'h20, 4, 1, 0, 0, 0);
        add(C,       8'h20, 8'h21, 4, 1, 0, 1, 0);
        add(H | CL,  8'h00, 8'h21, 4, 1, 0, 1, 0);
        add(CL,      8'h00, 8'h22, 4, 1, 0, 0, 0);
        add(R,       8'h00, 8'h21, 3, 0, 0, 0, 0);
        add(R,       8'h00, 8'h21, 2, 0, 0, 0, 0);
        add(H | R,   8'h00, 8'h21, 2, 0, 0, 0, 0);
        add(R,       8'h00, 8'h21, 1, 0, 0, 0, 0);
        add(R,       8'h00, 8'h01, 0, 0, 1, 0, 0);

        #2;
        chk("rst pm_addr", 32'(pm_addr), 0);
        chk_state("rst", 8'h00, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk("rst held pc", 32'(pc), 0);
        reset = 0;

        for (int i = 0; i < n; i++) begin
            drv(tbl[i].req, tbl[i].addr);
            #1;
            chk($sformatf("v%0d pm_addr", i), 32'(pm_addr), 32'(tbl[i].pc));
            @(posedge clk); #1;
            chk_state($sformatf("v%0d", i), tbl[i].pc, tbl[i].sp, tbl[i].full,
                      tbl[i].empty, tbl[i].ovf, tbl[i].unf);
        end

        drv(C, 8'h60);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_state("pre-rst", 8'h60, 2, 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        chk("async pc", 32'(pc), 0);
        chk("async pm_addr", 32'(pm_addr), 0);
        chk("async sp", 32'(sp), 0);
        chk("async empty", 32'(stack_empty), 1);
        @(posedge clk); #1;
        chk("async held pc", 32'(pc), 0);
        drv(R, 8'h00);
        reset = 0;
        @(posedge clk); #1;
        chk_state("post-rst ret", 8'h01, 0, 0, 1, 0, 1);
        drv(0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
